// File: rtl/sd_spi_pkg.sv
// Shared types and defaults for the SD-card SPI master.
package sd_spi_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int   DEF_CLK_DIV  = 12;
  localparam int   DEF_SLOW_DIV = 60;
  localparam logic MOSI_IDLE    = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sd_spi_tick.sv
// Half-period counter: tick is high in the cycle the count reaches half-1.
module sd_spi_tick #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] half,
  output logic         tick
);
  logic [W-1:0] cnt;

  assign tick = !clear && (cnt == half - W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else                    cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 master for the SD card link; CS is a separate register.
// Optional SD_SPI_SLOW_INIT_EN adds a 'slow' port selecting the init-rate half-period.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int SLOW_DIV = DEF_SLOW_DIV
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       cs_wr,
  input  logic       cs_val,
`ifdef SD_SPI_SLOW_INIT_EN
  input  logic       slow,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sd_sck,
  output logic       sd_cs,
  output logic       sd_sdi,
  input  logic       sd_sdo
);
  localparam int DW = $clog2(max2(CLK_DIV, SLOW_DIV));

  state_t        state;
  logic [7:0]    tx_shift, rx_shift;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] half;
  logic          tick;

`ifdef SD_SPI_SLOW_INIT_EN
  // Rate is frozen per byte so a mid-byte change of slow cannot skew SCK.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                       half <= DW'(CLK_DIV);
    else if (state == IDLE && start) half <= slow ? DW'(SLOW_DIV) : DW'(CLK_DIV);
  end
`else
  assign half = DW'(CLK_DIV);
`endif

  sd_spi_tick #(.W(DW)) u_tick (
    .clk   (clk_sys),
    .rst   (reset),
    .clear (state == IDLE || state == DONE),
    .half  (half),
    .tick  (tick)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= 8'h00;
      sd_sck   <= 1'b0;
      sd_sdi   <= MOSI_IDLE;
      tx_shift <= 8'h00;
      rx_shift <= 8'h00;
      bit_cnt  <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tx_shift <= tx_data;
          sd_sdi   <= tx_data[7];
          busy     <= 1'b1;
          bit_cnt  <= 3'd0;
          state    <= LOW;
        end
        LOW: if (tick) begin
          sd_sck   <= 1'b1;
          rx_shift <= {rx_shift[6:0], sd_sdo};
          state    <= HIGH;
        end
        HIGH: if (tick) begin
          sd_sck <= 1'b0;
          if (bit_cnt == 3'd7) begin
            state <= DONE;
          end else begin
            bit_cnt  <= bit_cnt + 3'd1;
            sd_sdi   <= tx_shift[6];
            tx_shift <= {tx_shift[6:0], 1'b0};
            state    <= LOW;
          end
        end
        DONE: begin
          done    <= 1'b1;
          rx_data <= rx_shift;
          busy    <= 1'b0;
          sd_sdi  <= MOSI_IDLE;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)      sd_cs <= 1'b1;
    else if (cs_wr) sd_cs <= cs_val;
  end
endmodule
